mp_add_seq: RTL and testbench

- Byte-serial multi-precision add sequencer for the 8-bit ripple-carry adder stage.
- Accepts operand byte pairs LSB-first over a valid/ready stream and drives the adder's x/y/cin combinationally.
- Captures the adder's f/cout in an output register and carries cout between beats of a frame, so N beats form an N*8-bit sum.
- Emits sum bytes, plus final carry and signed overflow, on a valid/ready output stream.

---
 rtl/mp_add_seq_if.sv | 54 +++++
 rtl/mp_add_seq.sv | 140 ++++++++++++++
 tb/tb_mp_add_seq.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mp_add_seq_if.sv
// Stream and adder-stage signal bundle for mp_add_seq.
// The in_sub port exists only when MP_ADD_SEQ_SUB_EN is defined.
interface mp_add_seq_if #(
  parameter int CNT_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic             in_first;
  logic             in_last;
  logic             in_cin;
`ifdef MP_ADD_SEQ_SUB_EN
  logic             in_sub;
`endif
  logic [7:0]       add_x;
  logic [7:0]       add_y;
  logic             add_cin;
  logic [7:0]       add_f;
  logic             add_cout;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_sum;
  logic             out_last;
  logic             out_cout;
  logic             out_ovf;
  logic [CNT_W-1:0] beat_cnt;
  logic             busy;
  logic             proto_err;

  // Sequencer side: consumes operand beats and adder results, produces sums.
  modport slave (
    input  in_valid, in_a, in_b, in_first, in_last, in_cin,
`ifdef MP_ADD_SEQ_SUB_EN
    input  in_sub,
`endif
    input  add_f, add_cout, out_ready,
    output in_ready, add_x, add_y, add_cin,
    output out_valid, out_sum, out_last, out_cout, out_ovf,
    output beat_cnt, busy, proto_err
  );

  // Environment side: upstream source, adder stage and downstream sink.
  modport master (
    output in_valid, in_a, in_b, in_first, in_last, in_cin,
`ifdef MP_ADD_SEQ_SUB_EN
    output in_sub,
`endif
    output add_f, add_cout, out_ready,
    input  in_ready, add_x, add_y, add_cin,
    input  out_valid, out_sum, out_last, out_cout, out_ovf,
    input  beat_cnt, busy, proto_err
  );
endinterface

// File: rtl/mp_add_seq.sv
// Byte-serial multi-precision add sequencer. Operand bytes arrive LSB-first,
// are routed straight to an external 8-bit ripple-carry adder, and the adder
// result is registered with the carry chained between beats of a frame.
// Optional feature macro: MP_ADD_SEQ_SUB_EN (adds in_sub for A-B frames).
module mp_add_seq #(
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = 5
) (
  input logic         clk,
  input logic         rst_n,
  mp_add_seq_if.slave bus
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [0:0]       state_q;
  logic             carry_q;
  logic             out_valid_q;
  logic [7:0]       sum_q;
  logic             last_q;
  logic             cout_q;
  logic             ovf_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  logic             in_ready;
  logic             accept;
  logic             sub_now;
  logic [7:0]       y_eff;
  logic             beat_ovf;
  logic             over_limit;
  logic             err_d;

`ifdef MP_ADD_SEQ_SUB_EN
  logic             sub_q;

  // A first beat decides the operation for itself; later beats follow the latch.
  assign sub_now = bus.in_first ? bus.in_sub : sub_q;

  // Latch the operation for the rest of the frame whenever a frame starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q <= 1'b0;
    end else if (accept && bus.in_first) begin
      sub_q <= bus.in_sub;
    end
  end
`else
  assign sub_now = 1'b0;
`endif

  // Single output register: a new beat fits when the register is empty or draining.
  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  // Subtraction is A + ~B + 1, so the first beat forces carry-in high.
  assign y_eff       = sub_now ? ~bus.in_b : bus.in_b;
  assign bus.add_x   = bus.in_a;
  assign bus.add_y   = y_eff;
  assign bus.add_cin = bus.in_first ? (sub_now | bus.in_cin) : carry_q;

  // Signed overflow: operands agree in sign but the result does not.
  assign beat_ovf = (bus.in_a[7] == y_eff[7]) && (bus.add_f[7] != bus.in_a[7]);

  // A non-first beat arriving with the counter already full overruns the frame.
  assign over_limit = (state_q == ACTIVE) && !bus.in_first && (cnt_q == CNT_MAX);
  assign err_d = ((state_q == IDLE)   && !bus.in_first) ||
                 ((state_q == ACTIVE) &&  bus.in_first) ||
                 over_limit;

  // Frame tracking: a last beat always closes, a first beat (or stray IDLE beat) opens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (accept) begin
      if (bus.in_last) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else if ((state_q == IDLE) || bus.in_first) begin
        state_q <= ACTIVE;
        cnt_q   <= CNT_ONE;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q   <= cnt_q + CNT_ONE;
      end
    end
  end

  // Inter-beat carry; cleared at frame end so a stray next beat starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
    end else if (accept) begin
      carry_q <= bus.in_last ? 1'b0 : bus.add_cout;
    end
  end

  // Output register: load on accept, drop valid when drained, hold when stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      last_q      <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      sum_q       <= bus.add_f;
      last_q      <= bus.in_last;
      cout_q      <= bus.in_last ? bus.add_cout : 1'b0;
      ovf_q       <= bus.in_last ? beat_ovf : 1'b0;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Protocol error flag lasts exactly one cycle after the offending beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept && err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_last  = last_q;
  assign bus.out_cout  = cout_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.beat_cnt  = cnt_q;
  assign bus.busy      = (state_q == ACTIVE);
  assign bus.proto_err = err_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Scoreboard bench for mp_add_seq: stimulus pushes hand-computed sum beats,
// a monitor pops them as the DUT hands each beat downstream.
module tb_mp_add_seq;

  localparam int CNT_W     = 5;
  localparam int MAX_BEATS = 16;

  typedef struct packed {
    logic [7:0] sum;
    logic       last;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;
  exp_t sb[$];

  mp_add_seq_if #(.CNT_W(CNT_W)) bus ();

  mp_add_seq #(.MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural 8-bit ripple-carry adder stage the sequencer drives.
  assign {bus.add_cout, bus.add_f} = {1'b0, bus.add_x} + {1'b0, bus.add_y} + {8'b0, bus.add_cin};

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one beat, push its expected result, hold until it is accepted.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic first, input logic last, input logic cin,
                               input logic [7:0] es, input logic el,
                               input logic ec, input logic eo);
    bit ok;
    exp_t e;
    ok = 0;
    e.sum = es; e.last = el; e.cout = ec; e.ovf = eo;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_first = first;
    bus.in_last  = last;
    bus.in_cin   = cin;
    bus.in_valid = 1'b1;
    sb.push_back(e);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 expected 1");
      void'(sb.pop_back());
    end
    bus.in_valid = 1'b0;
  endtask

  // Monitor: every beat handed downstream is matched against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL unexpected_beat: got sum=%0h with empty scoreboard", bus.out_sum);
      end else begin
        e = sb.pop_front();
        if ({bus.out_sum, bus.out_last, bus.out_cout, bus.out_ovf} !== e) begin
          mismatched++;
          $display("[TB] FAIL sum_beat: got sum=%0h last=%0b cout=%0b ovf=%0b expected sum=%0h last=%0b cout=%0b ovf=%0b",
                   bus.out_sum, bus.out_last, bus.out_cout, bus.out_ovf,
                   e.sum, e.last, e.cout, e.ovf);
        end
      end
    end
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_cin   = 1'b0;
`ifdef MP_ADD_SEQ_SUB_EN
    bus.in_sub   = 1'b0;
`endif
    bus.out_ready = 1'b1;

    #12;
    checkOutput("rst_out_valid", 32'(bus.out_valid), 0);
    checkOutput("rst_out_sum",   32'(bus.out_sum),   0);
    checkOutput("rst_beat_cnt",  32'(bus.beat_cnt),  0);
    checkOutput("rst_busy",      32'(bus.busy),      0);
    checkOutput("rst_proto_err", 32'(bus.proto_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single beat 7F+01");
    applyStimulus(8'h7F, 8'h01, 1, 1, 0, 8'h80, 1, 0, 1);
    checkOutput("single_cnt",  32'(bus.beat_cnt), 0);
    checkOutput("single_busy", 32'(bus.busy),     0);

    $display("[TB] single beat 80+80 cin=1");
    applyStimulus(8'h80, 8'h80, 1, 1, 1, 8'h01, 1, 1, 1);

    $display("[TB] two beat 12FF+0001");
    applyStimulus(8'hFF, 8'h01, 1, 0, 0, 8'h00, 0, 0, 0);
    checkOutput("two_cnt1",  32'(bus.beat_cnt), 1);
    checkOutput("two_busy1", 32'(bus.busy),     1);
    applyStimulus(8'h12, 8'h00, 0, 1, 0, 8'h13, 1, 0, 0);
    checkOutput("two_cnt2",  32'(bus.beat_cnt), 0);
    checkOutput("two_busy2", 32'(bus.busy),     0);

    $display("[TB] backpressure mid-frame");
    applyStimulus(8'hFF, 8'h01, 1, 0, 0, 8'h00, 0, 0, 0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_in_ready",  32'(bus.in_ready),  0);
      checkOutput("bp_out_valid", 32'(bus.out_valid), 1);
      checkOutput("bp_out_sum",   32'(bus.out_sum),   8'h00);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    applyStimulus(8'h80, 8'h80, 0, 0, 0, 8'h01, 0, 0, 0);
    checkOutput("bp_cnt2", 32'(bus.beat_cnt), 2);
    applyStimulus(8'h01, 8'h00, 0, 1, 0, 8'h02, 1, 0, 0);

    $display("[TB] stray beat in IDLE");
    applyStimulus(8'h10, 8'h20, 0, 1, 1, 8'h30, 1, 0, 0);
    checkOutput("idle_err_pulse", 32'(bus.proto_err), 1);
    @(posedge clk);
    #1;
    checkOutput("idle_err_clear", 32'(bus.proto_err), 0);

    $display("[TB] restart inside frame");
    applyStimulus(8'h01, 8'h01, 1, 0, 0, 8'h02, 0, 0, 0);
    checkOutput("restart_no_err", 32'(bus.proto_err), 0);
    applyStimulus(8'h03, 8'h04, 1, 0, 1, 8'h08, 0, 0, 0);
    checkOutput("restart_err", 32'(bus.proto_err), 1);
    checkOutput("restart_cnt", 32'(bus.beat_cnt),  1);
    applyStimulus(8'h00, 8'h00, 0, 1, 0, 8'h00, 1, 0, 0);
    checkOutput("restart_end_cnt", 32'(bus.beat_cnt), 0);

    $display("[TB] frame overrun");
    for (int i = 0; i < MAX_BEATS; i++) begin
      applyStimulus(8'h00, 8'h00, (i == 0), 0, 0, 8'h00, 0, 0, 0);
    end
    checkOutput("full_cnt", 32'(bus.beat_cnt),  MAX_BEATS);
    checkOutput("full_err", 32'(bus.proto_err), 0);
    applyStimulus(8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);
    checkOutput("over_err", 32'(bus.proto_err), 1);
    checkOutput("over_cnt", 32'(bus.beat_cnt),  MAX_BEATS);
    applyStimulus(8'h00, 8'h00, 0, 1, 0, 8'h00, 1, 0, 0);
    checkOutput("over_end_cnt",  32'(bus.beat_cnt), 0);
    checkOutput("over_end_busy", 32'(bus.busy),     0);

    $display("[TB] async reset mid-frame");
    applyStimulus(8'h11, 8'h22, 1, 0, 0, 8'h33, 0, 0, 0);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    checkOutput("arst_out_valid", 32'(bus.out_valid), 0);
    checkOutput("arst_busy",      32'(bus.busy),      0);
    checkOutput("arst_cnt",       32'(bus.beat_cnt),  0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(8'hFF, 8'h01, 1, 1, 0, 8'h00, 1, 1, 0);

`ifdef MP_ADD_SEQ_SUB_EN
    $display("[TB] subtract 05-07");
    bus.in_sub = 1'b1;
    applyStimulus(8'h05, 8'h07, 1, 1, 0, 8'hFE, 1, 0, 0);
    bus.in_sub = 1'b0;
`endif

    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    checkOutput("drain", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
